// File: rtl/divider_pkg.sv
// Shared types and defaults for the 16/8 sequential restoring divider.
package divider_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported when the captured divisor is zero.
  function automatic logic [DEF_DIVIDEND_W-1:0] dbz_quotient();
    return {DEF_DIVIDEND_W{1'b1}};
  endfunction

endpackage

// File: rtl/divider_16_8_seq_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface divider_16_8_seq_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  ready;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// conditionally subtract the divisor and emit the quotient bit.
module div_restore_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   i_prem,
  input  logic                 i_msb,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_prem_next,
  output logic                 o_qbit
);

  logic [DIVISOR_W:0] w_shift;
  logic [DIVISOR_W:0] w_diff;
  logic               w_ge;

  // The incoming remainder is always below the divisor, so its top bit is
  // normally clear; if set, the shifted value certainly exceeds the divisor.
  assign w_shift     = {i_prem[DIVISOR_W-1:0], i_msb};
  assign w_ge        = i_prem[DIVISOR_W] | (w_shift >= {1'b0, i_divisor});
  assign w_diff      = w_shift - {1'b0, i_divisor};
  assign o_prem_next = w_ge ? w_diff : w_shift;
  assign o_qbit      = w_ge;

endmodule

// File: rtl/divider_16_8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/ready/done handshake and divide-by-zero reporting.
module divider_16_8_seq
  import divider_pkg::*;
#(
  parameter  int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter  int DIVISOR_W  = DEF_DIVISOR_W,
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1)
) (
  input  logic clk,
  input  logic rst,
  divider_16_8_seq_if.slave bus
);

  div_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W:0]    r_prem;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbz;
  logic                  r_done;
  logic                  r_ready;

  logic [DIVISOR_W:0]    w_prem_next;
  logic                  w_qbit;

  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .i_prem      (r_prem),
    .i_msb       (r_dvd[DIVIDEND_W-1]),
    .i_divisor   (r_dvs),
    .o_prem_next (w_prem_next),
    .o_qbit      (w_qbit)
  );

  // r_dvd doubles as the quotient accumulator: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_prem  <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dvd   <= bus.dividend;
            r_dvs   <= bus.divisor;
            r_prem  <= '0;
            r_ready <= 1'b0;
            if (bus.divisor != '0) begin
              r_cnt   <= CNT_W'(DIVIDEND_W);
              r_state <= BUSY;
            end else begin
              r_quot  <= DIVIDEND_W'(dbz_quotient());
              r_rem   <= bus.dividend[DIVISOR_W-1:0];
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        BUSY: begin
          r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
          r_prem <= w_prem_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_quot  <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
            r_rem   <= w_prem_next[DIVISOR_W-1:0];
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_16_8_seq.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and randomized operands against a plain-arithmetic reference model.
module tb_divider_16_8_seq;

  logic clk;
  logic rst;

  divider_16_8_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

  divider_16_8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  vec_t tbl [9];
  int   n_vec;
  int   n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: ordinary integer division, with the divide-by-zero convention.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      z = 1'b0;
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r, output logic z,
                         output int lat, output bit held_ok, output bit pulse_ok);
    int n;
    logic [15:0] q0;
    n = 0;
    while (!bus.ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.ready) chk("ready_wait", {31'd0, bus.ready}, 32'd1);
    q0 = bus.quotient;
    held_ok = 1'b1;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor = 8'($urandom);
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (bus.quotient !== q0) held_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    @(posedge clk); #1;
    pulse_ok = (!bus.done && bus.ready);
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                              input logic [15:0] eq, input logic [7:0] er, input logic ez);
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    bit          held_ok, pulse_ok;
    run_div(a, b, q, r, z, lat, held_ok, pulse_ok);
    $display("%s: %04h / %02h -> q=%04h r=%02h dbz=%0b lat=%0d", tag, a, b, q, r, z, lat);
    chk({tag, "_quotient"}, {16'd0, q}, {16'd0, eq});
    chk({tag, "_remainder"}, {24'd0, r}, {24'd0, er});
    chk({tag, "_dbz"}, {31'd0, z}, {31'd0, ez});
    chk({tag, "_latency"}, lat, (b == 8'd0) ? 32'd0 : 32'd16);
    chk({tag, "_hold"}, {31'd0, held_ok}, 32'd1);
    chk({tag, "_one_pulse"}, {31'd0, pulse_ok}, 32'd1);
  endtask

  initial begin
    logic [15:0] a, eq;
    logic [7:0]  b, er;
    logic        ez;
    int          pulses, done_at;
    logic [15:0] cap_q;
    logic [7:0]  cap_r;

    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{16'h000F, 8'h03, 16'h0005, 8'h00, 1'b0};
    tbl[1] = '{16'h7887, 8'hFF, 16'h0079, 8'h00, 1'b0};
    tbl[2] = '{16'h064C, 8'h1F, 16'h0034, 8'h00, 1'b0};
    tbl[3] = '{16'h00AA, 8'h01, 16'h00AA, 8'h00, 1'b0};
    tbl[4] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0};
    tbl[5] = '{16'd1000, 8'd7,  16'd142,  8'd6,  1'b0};
    tbl[6] = '{16'h0005, 8'hFF, 16'h0000, 8'h05, 1'b0};
    tbl[7] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1};
    tbl[8] = '{16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", {31'd0, bus.ready}, 32'd1);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_quotient", {16'd0, bus.quotient}, 32'd0);
    chk("reset_remainder", {24'd0, bus.remainder}, 32'd0);
    chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    for (int i = 0; i < 9; i++)
      check_result($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);

    // Start held high with changing operands throughout BUSY and DONE.
    model(16'h1234, 8'h07, eq, er, ez);
    bus.start = 1'b1;
    bus.dividend = 16'h1234;
    bus.divisor = 8'h07;
    @(posedge clk); #1;
    pulses = 0;
    done_at = -1;
    cap_q = '0;
    cap_r = '0;
    for (int i = 1; i <= 20; i++) begin
      bus.dividend = 16'($urandom);
      bus.divisor = 8'($urandom);
      bus.start = (i < 17);
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        done_at = i;
        cap_q = bus.quotient;
        cap_r = bus.remainder;
      end
    end
    $display("ignore_start: 1234 / 07 -> q=%04h r=%02h pulses=%0d at=%0d", cap_q, cap_r, pulses, done_at);
    chk("ignore_pulses", pulses, 32'd1);
    chk("ignore_latency", done_at, 32'd16);
    chk("ignore_quotient", {16'd0, cap_q}, {16'd0, eq});
    chk("ignore_remainder", {24'd0, cap_r}, {24'd0, er});

    // Reset during BUSY aborts without a done pulse.
    bus.start = 1'b1;
    bus.dividend = 16'h0100;
    bus.divisor = 8'h02;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("abort: q=%04h r=%02h dbz=%0b ready=%0b done=%0b",
             bus.quotient, bus.remainder, bus.div_by_zero, bus.ready, bus.done);
    chk("abort_ready", {31'd0, bus.ready}, 32'd1);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_quotient", {16'd0, bus.quotient}, 32'd0);
    chk("abort_remainder", {24'd0, bus.remainder}, 32'd0);
    chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("abort_no_done", pulses, 32'd0);
    check_result("after_abort", 16'h0100, 8'h02, 16'h0080, 8'h00, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = (i % 10 == 9) ? 8'd0 : 8'($urandom_range(0, 255));
      model(a, b, eq, er, ez);
      check_result($sformatf("rand%0d", i), a, b, eq, er, ez);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
